// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : LoongArch instruction-fetch stage: next-PC selection, sync SRAM
//            read, valid/allowin handoff to decode, branch redirect handling.
// Build    : define IF_INST_BUF_EN to keep a stalled instruction in a local
//            buffer instead of relying on the SRAM holding its output.
// Revision : 1.0  initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_allowin,
  input  logic        id_br_taken,
  input  logic [31:0] id_br_target,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_to_id_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] PC_RESET_Q  = RESET_PC - PC_STEP;

  logic [31:0] fs_pc_q,      fs_pc_d;
  logic        fs_valid_q,   fs_valid_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_target_q,  br_target_d;

  logic        fs_allowin;
  logic        br_kill;
  logic        fetch;
  logic [31:0] nextpc;

  always_comb begin
    fs_allowin = ~fs_valid_q | id_allowin;
    // Redirect that cannot be serviced this cycle: remember it, drop IF.
    br_kill    = id_br_taken & fs_valid_q & ~id_allowin;
    fetch      = fs_allowin & ~reset;
    if (id_br_taken) begin
      nextpc = id_br_target;
    end else if (br_pending_q) begin
      nextpc = br_target_q;
    end else begin
      nextpc = fs_pc_q + PC_STEP;
    end
  end

  always_comb begin
    fs_pc_d      = fs_pc_q;
    fs_valid_d   = fs_valid_q;
    br_pending_d = br_pending_q;
    br_target_d  = br_target_q;
    if (fetch) begin
      fs_pc_d      = nextpc;
      fs_valid_d   = 1'b1;
      br_pending_d = 1'b0;
    end else if (br_kill) begin
      fs_valid_d   = 1'b0;
      br_pending_d = 1'b1;
      br_target_d  = id_br_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_pc_q      <= PC_RESET_Q;
      fs_valid_q   <= 1'b0;
      br_pending_q <= 1'b0;
      br_target_q  <= 32'h0;
    end else begin
      fs_pc_q      <= fs_pc_d;
      fs_valid_q   <= fs_valid_d;
      br_pending_q <= br_pending_d;
      br_target_q  <= br_target_d;
    end
  end

`ifdef IF_INST_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q,  inst_buf_d;

  always_comb begin
    buf_valid_d = buf_valid_q;
    inst_buf_d  = inst_buf_q;
    if (fetch || br_kill) begin
      buf_valid_d = 1'b0;
    end else if (fs_valid_q && !id_allowin && !buf_valid_q) begin
      // First stalled cycle: SRAM output is still the fetched word.
      buf_valid_d = 1'b1;
      inst_buf_d  = inst_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      inst_buf_q  <= 32'h0;
    end else begin
      buf_valid_q <= buf_valid_d;
      inst_buf_q  <= inst_buf_d;
    end
  end

  assign if_inst = buf_valid_q ? inst_buf_q : inst_sram_rdata;
`else
  assign if_inst = inst_sram_rdata;
`endif

  assign inst_sram_en    = fetch;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;
  assign if_to_id_valid  = fs_valid_q & ~id_br_taken & ~br_pending_q;
  assign if_pc           = fs_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// Testbench for if_stage: directed walk through reset, stall, redirect and
// wrap cases, then randomized allowin/branch traffic against a stream model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_allowin;
  logic        id_br_taken;
  logic [31:0] id_br_target;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        if_to_id_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  bit sb_on  = 1'b0;
  logic [31:0] exp_q[$];

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .id_allowin(id_allowin),
    .id_br_taken(id_br_taken), .id_br_target(id_br_target),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata), .if_to_id_valid(if_to_id_valid),
    .if_inst(if_inst), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Synchronous SRAM: holds its output unless the buffered build is tested.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
`ifdef IF_INST_BUF_EN
    else              inst_sram_rdata <= $urandom;
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected in-order stream of PCs decode should receive.
  task automatic topup();
    while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
  endtask

  always @(negedge clk) begin
    if (sb_on && if_to_id_valid && id_allowin) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got pc %h expected none", if_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", if_pc, e);
        chk("sb_inst", if_inst, mem(e));
      end
    end
  end

  initial begin
    reset = 1'b1; id_allowin = 1'b1; id_br_taken = 1'b0; id_br_target = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_en", {31'h0, inst_sram_en}, 32'h0);
    chk("rst_valid", {31'h0, if_to_id_valid}, 32'h0);
    chk("rst_pc", if_pc, RESET_PC - 32'd4);
    chk("sram_we", {28'h0, inst_sram_we}, 32'h0);
    chk("sram_wdata", inst_sram_wdata, 32'h0);

    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("c0_en", {31'h0, inst_sram_en}, 32'h1);
    chk("c0_addr", inst_sram_addr, 32'h1c00_0000);
    chk("c0_valid", {31'h0, if_to_id_valid}, 32'h0);
    step(); @(negedge clk);
    chk("c1_addr", inst_sram_addr, 32'h1c00_0004);
    chk("c1_pc", if_pc, 32'h1c00_0000);
    chk("c1_valid", {31'h0, if_to_id_valid}, 32'h1);
    chk("c1_inst", if_inst, mem(32'h1c00_0000));
    step(); @(negedge clk);
    chk("c2_addr", inst_sram_addr, 32'h1c00_0008);
    chk("c2_pc", if_pc, 32'h1c00_0004);

    step(); id_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_en", {31'h0, inst_sram_en}, 32'h0);
      chk("stall_pc", if_pc, 32'h1c00_0008);
      chk("stall_inst", if_inst, mem(32'h1c00_0008));
      chk("stall_valid", {31'h0, if_to_id_valid}, 32'h1);
      step();
    end

    id_allowin = 1'b1; id_br_taken = 1'b1; id_br_target = 32'h1c00_0100;
    @(negedge clk);
    chk("br_valid", {31'h0, if_to_id_valid}, 32'h0);
    chk("br_addr", inst_sram_addr, 32'h1c00_0100);
    chk("br_en", {31'h0, inst_sram_en}, 32'h1);
    step(); id_br_taken = 1'b0;
    @(negedge clk);
    chk("br_pc", if_pc, 32'h1c00_0100);
    chk("br_pc_valid", {31'h0, if_to_id_valid}, 32'h1);
    chk("br_inst", if_inst, mem(32'h1c00_0100));

    step(); id_allowin = 1'b0; id_br_taken = 1'b1; id_br_target = 32'h1c00_0200;
    @(negedge clk);
    chk("pend0_valid", {31'h0, if_to_id_valid}, 32'h0);
    chk("pend0_en", {31'h0, inst_sram_en}, 32'h0);
    step(); id_br_taken = 1'b0;
    @(negedge clk);
    chk("pend1_valid", {31'h0, if_to_id_valid}, 32'h0);
    chk("pend1_en", {31'h0, inst_sram_en}, 32'h1);
    chk("pend1_addr", inst_sram_addr, 32'h1c00_0200);
    step(); @(negedge clk);
    chk("pend2_pc", if_pc, 32'h1c00_0200);
    chk("pend2_valid", {31'h0, if_to_id_valid}, 32'h1);
    chk("pend2_inst", if_inst, mem(32'h1c00_0200));

    step(); id_allowin = 1'b1; id_br_taken = 1'b1; id_br_target = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("wrap_addr0", inst_sram_addr, 32'hFFFF_FFFC);
    step(); id_br_taken = 1'b0;
    @(negedge clk);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_addr1", inst_sram_addr, 32'h0000_0000);
    step(); @(negedge clk);
    chk("wrap_pc0", if_pc, 32'h0000_0000);
    chk("wrap_inst0", if_inst, mem(32'h0));

    step(); reset = 1'b1;
    #1;
    chk("mrst_valid", {31'h0, if_to_id_valid}, 32'h0);
    chk("mrst_en", {31'h0, inst_sram_en}, 32'h0);
    chk("mrst_pc", if_pc, RESET_PC - 32'd4);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    topup();
    sb_on = 1'b1;
    step(); reset = 1'b0;
    @(negedge clk);
    chk("rel_addr", inst_sram_addr, 32'h1c00_0000);
    chk("rel_en", {31'h0, inst_sram_en}, 32'h1);

    for (int n = 0; n < 3000; n++) begin
      step();
      id_allowin  = ($urandom_range(0, 3) != 0);
      id_br_taken = ($urandom_range(0, 7) == 0);
      if (id_br_taken) begin
        if ($urandom_range(0, 3) == 0)
          id_br_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        else
          id_br_target = $urandom;
        exp_q.delete();
        exp_q.push_back(id_br_target);
      end
      topup();
    end
    step();
    id_br_taken = 1'b0;
    sb_on = 1'b0;

    checks++;
    if (hs_cnt <= 200) begin
      errors++;
      $display("FAIL liveness: got %0d handshakes expected more than 200", hs_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
